// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, FSM state
// encoding, datapath mux encodings and the packed control-bus payload.
package multicycle_control_pkg;

   localparam int unsigned OP_SIZE = 6;
   localparam int unsigned STATE_W = 4;

   typedef logic [OP_SIZE-1:0] opcode_t;

   // Opcodes decoded by the controller (IR[31:26])
   localparam opcode_t OP_RTYPE = 6'h00;
   localparam opcode_t OP_BGEZ  = 6'h01;
   localparam opcode_t OP_J     = 6'h02;
   localparam opcode_t OP_BEQ   = 6'h04;
   localparam opcode_t OP_ADDI  = 6'h08;
   localparam opcode_t OP_SLTI  = 6'h0A;
   localparam opcode_t OP_ANDI  = 6'h0C;
   localparam opcode_t OP_ORI   = 6'h0D;
   localparam opcode_t OP_LUI   = 6'h0F;
   localparam opcode_t OP_LB    = 6'h20;
   localparam opcode_t OP_LH    = 6'h21;
   localparam opcode_t OP_SB    = 6'h28;
   localparam opcode_t OP_SH    = 6'h29;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_IMM_EXEC  = 4'd10,
      S_IMM_WB    = 4'd11
   } state_t;

   // ALUOp encoding, shared with alu_control
   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
   localparam logic [1:0] ALU_OP_ITYPE = 2'b11;

   // ALU B-operand mux encoding
   localparam logic [1:0] SRC_B_REG    = 2'b00;
   localparam logic [1:0] SRC_B_FOUR   = 2'b01;
   localparam logic [1:0] SRC_B_IMM    = 2'b10;
   localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

   // PC source mux encoding
   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ge;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   function automatic logic is_store(input opcode_t op);
      return (op == OP_SB) || (op == OP_SH);
   endfunction

endpackage

// File: rtl/multicycle_control_retire_counter.sv
// Retired-instruction counter; wraps at 2^CNT_W.
//   clk   : clock, rising edge
//   rst   : synchronous active-high clear
//   inc   : add one on this edge
//   count : current count
module multicycle_control_retire_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Moore main controller for the multi-cycle MIPS datapath. Sequences the
// shared ALU and unified memory over 3-5 cycles per instruction, stalls on
// mem_ready, flags undefined opcodes and counts retired instructions.
//   clk, rst                     : clock and synchronous active-high reset
//   opcode                       : IR[31:26], sampled in DECODE only
//   mem_ready                    : memory finished the current access
//   pc_write .. pc_source        : datapath enables and mux selects
//   illegal_op                   : sticky undefined-opcode flag
//   retired_count                : completed instructions, wraps
//   state                        : current FSM state (debug)
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [OP_SIZE-1:0]    opcode,
   input  logic                  mem_ready,
   output logic                  pc_write,
   output logic                  pc_write_cond,
   output logic                  branch_ge,
   output logic                  iord,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic                  ir_write,
   output logic                  mem_to_reg,
   output logic                  reg_dst,
   output logic                  reg_write,
   output logic                  alu_src_a,
   output logic [1:0]            alu_src_b,
   output logic [1:0]            alu_op,
   output logic [1:0]            pc_source,
   output logic                  illegal_op,
   output logic [CNT_W-1:0]      retired_count,
   output logic [STATE_W-1:0]    state
);

   state_t  state_q;
   state_t  state_d;
   opcode_t op_q;
   logic    illegal_q;
   logic    illegal_set_c;
   logic    retire_c;
   ctrl_t   ctrl_c;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Opcode copy used by every state after DECODE
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q <= '0;
      end else if (state_q == S_DECODE) begin
         op_q <= opcode;
      end
   end

   // Sticky illegal-opcode flag
   always_ff @(posedge clk) begin
      if (rst) begin
         illegal_q <= 1'b0;
      end else if (illegal_set_c) begin
         illegal_q <= 1'b1;
      end
   end

   // Next state, retire and illegal-opcode detection
   always_comb begin
      state_d       = state_q;
      illegal_set_c = 1'b0;
      retire_c      = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:                         state_d = S_EXECUTE;
               OP_LB, OP_LH, OP_SB, OP_SH:       state_d = S_MEM_ADDR;
               OP_BEQ, OP_BGEZ:                  state_d = S_BRANCH;
               OP_ADDI, OP_ORI, OP_ANDI,
               OP_SLTI, OP_LUI:                  state_d = S_IMM_EXEC;
               OP_J:                             state_d = S_JUMP;
               default: begin
                  state_d       = S_FETCH;
                  illegal_set_c = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR:  state_d = is_store(op_q) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ: begin
            if (mem_ready) state_d = S_MEM_WB;
         end
         S_MEM_WRITE: begin
            if (mem_ready) begin
               state_d  = S_FETCH;
               retire_c = 1'b1;
            end
         end
         S_EXECUTE:   state_d = S_R_WB;
         S_IMM_EXEC:  state_d = S_IMM_WB;
         S_MEM_WB, S_R_WB, S_IMM_WB, S_BRANCH, S_JUMP: begin
            state_d  = S_FETCH;
            retire_c = 1'b1;
         end
         default:     state_d = S_FETCH;
      endcase
   end

   // Control outputs by state; FETCH gates ir_write/pc_write on mem_ready
   always_comb begin
      ctrl_c = '0;
      case (state_q)
         S_FETCH: begin
            ctrl_c.mem_read  = 1'b1;
            ctrl_c.alu_src_b = SRC_B_FOUR;
            ctrl_c.alu_op    = ALU_OP_ADD;
            ctrl_c.pc_source = PC_SRC_ALU;
            ctrl_c.ir_write  = mem_ready;
            ctrl_c.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl_c.alu_src_b = SRC_B_IMM_SH;
            ctrl_c.alu_op    = ALU_OP_ADD;
         end
         S_MEM_ADDR: begin
            ctrl_c.alu_src_a = 1'b1;
            ctrl_c.alu_src_b = SRC_B_IMM;
            ctrl_c.alu_op    = ALU_OP_ADD;
         end
         S_MEM_READ: begin
            ctrl_c.mem_read = 1'b1;
            ctrl_c.iord     = 1'b1;
         end
         S_MEM_WB: begin
            ctrl_c.reg_write  = 1'b1;
            ctrl_c.mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            ctrl_c.mem_write = 1'b1;
            ctrl_c.iord      = 1'b1;
         end
         S_EXECUTE: begin
            ctrl_c.alu_src_a = 1'b1;
            ctrl_c.alu_src_b = SRC_B_REG;
            ctrl_c.alu_op    = ALU_OP_FUNCT;
         end
         S_R_WB: begin
            ctrl_c.reg_write = 1'b1;
            ctrl_c.reg_dst   = 1'b1;
         end
         S_IMM_EXEC: begin
            ctrl_c.alu_src_a = 1'b1;
            ctrl_c.alu_src_b = SRC_B_IMM;
            ctrl_c.alu_op    = ALU_OP_ITYPE;
         end
         S_IMM_WB: begin
            ctrl_c.reg_write = 1'b1;
         end
         S_BRANCH: begin
            ctrl_c.alu_src_a     = 1'b1;
            ctrl_c.alu_src_b     = SRC_B_REG;
            ctrl_c.alu_op        = ALU_OP_SUB;
            ctrl_c.pc_write_cond = 1'b1;
            ctrl_c.pc_source     = PC_SRC_ALUOUT;
            ctrl_c.branch_ge     = (op_q == OP_BGEZ);
         end
         S_JUMP: begin
            ctrl_c.pc_write  = 1'b1;
            ctrl_c.pc_source = PC_SRC_JUMP;
         end
         default: ctrl_c = '0;
      endcase
      // Reset overrides everything so no strobe fires while it is held
      if (rst) ctrl_c = '0;
   end

   multicycle_control_retire_counter #(
      .CNT_W (CNT_W)
   ) u_retire (
      .clk   (clk),
      .rst   (rst),
      .inc   (retire_c),
      .count (retired_count)
   );

   assign pc_write      = ctrl_c.pc_write;
   assign pc_write_cond = ctrl_c.pc_write_cond;
   assign branch_ge     = ctrl_c.branch_ge;
   assign iord          = ctrl_c.iord;
   assign mem_read      = ctrl_c.mem_read;
   assign mem_write     = ctrl_c.mem_write;
   assign ir_write      = ctrl_c.ir_write;
   assign mem_to_reg    = ctrl_c.mem_to_reg;
   assign reg_dst       = ctrl_c.reg_dst;
   assign reg_write     = ctrl_c.reg_write;
   assign alu_src_a     = ctrl_c.alu_src_a;
   assign alu_src_b     = ctrl_c.alu_src_b;
   assign alu_op        = ctrl_c.alu_op;
   assign pc_source     = ctrl_c.pc_source;
   assign illegal_op    = illegal_q;
   assign state         = STATE_W'(state_q);

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore-style main controller for the multi-cycle MIPS datapath. It sequences one shared ALU and one unified instruction/data memory across 3-5 cycles per instruction. It decodes the same opcode set as the single-cycle control unit, stalls on a memory ready handshake, and counts retired instructions. It sits between the instruction register opcode field and the datapath muxes and enables.

Parameters:
OP_SIZE, 6, opcode width; shared with parameters.v
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
opcode  in  OP_SIZE  IR[31:26]; sampled only in DECODE
mem_ready  in  1  memory completed current access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if branch condition true
branch_ge  out  1  1 = condition is rs>=0 (BGEZ); 0 = zero flag (BEQ)
iord  out  1  memory address mux: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
mem_to_reg  out  1  writeback mux: 1 = MDR, 0 = ALUOut
reg_dst  out  1  dest mux: 1 = rd, 0 = rt
reg_write  out  1  register file write
alu_src_a  out  1  0 = PC, 1 = reg A
alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
alu_op  out  2  00 = add, 01 = sub, 10 = funct, 11 = I-type by opcode
pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal_op  out  1  sticky; set on an undefined opcode
retired_count  out  CNT_W  instructions completed, wraps
state  out  4  current state, for debug/verification

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, IMM_EXEC=10, IMM_WB=11. Codes 12-15 are unused and go to FETCH on the next edge.
- Reset (rst=1 at the clk edge):
  - state=FETCH, illegal_op=0, retired_count=0.
  - While rst is high, all control outputs are forced to 0, overriding the FETCH decode.
  - Reset mid-instruction aborts it; no write strobe is asserted after that edge.
- Outputs are a pure function of state; there are no opcode-dependent outputs outside DECODE-derived states.
- Per-state outputs (all unlisted outputs are 0):
  - FETCH: mem_read, alu_src_b=01, alu_op=00, pc_source=00.
    - ir_write and pc_write are asserted only when mem_ready=1. This is the single Mealy exception.
    - Remains in FETCH while mem_ready=0.
  - DECODE: alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
    - RTYPE -> EXECUTE
    - LB/LH/SB/SH -> MEM_ADDR
    - BEQ/BGEZ -> BRANCH
    - ADDI/ORI/ANDI/SLTI/LUI -> IMM_EXEC
    - J -> JUMP
    - any other opcode -> FETCH, sets illegal_op, not counted as retired
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEM_READ for loads, MEM_WRITE for stores.
  - MEM_READ: mem_read, iord. Waits for mem_ready, then goes to MEM_WB.
  - MEM_WB: reg_write, mem_to_reg. Next is FETCH.
  - MEM_WRITE: mem_write, iord. Waits for mem_ready, then goes to FETCH.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next is R_WB.
  - R_WB: reg_write, reg_dst. Next is FETCH.
  - IMM_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11. Next is IMM_WB.
  - IMM_WB: reg_write, reg_dst=0. Next is FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond, pc_source=01, branch_ge=(latched opcode==BGEZ). Next is FETCH.
  - JUMP: pc_write, pc_source=10. Next is FETCH.
- Opcode is latched into an internal register in DECODE. Later states use the latched copy, never the live input.
- Latency with mem_ready held at 1:
  - R-type: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - I-type ALU: 4 cycles
  - branch: 3 cycles
  - jump: 3 cycles
  - Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- retired_count increments by 1 on each edge leaving MEM_WB, MEM_WRITE (with mem_ready), R_WB, IMM_WB, BRANCH or JUMP into FETCH. It wraps from 2^CNT_W-1 to 0.
- illegal_op is cleared only by rst.

Decomposition:
- Package/parameters.v holds:
  - OP_* opcode constants
  - the state encoding localparams
  - ALUOp, alu_src_b and pc_source encodings, shared with alu_control and the datapath muxes
- No sub-module is needed. The optional retire counter may be split out as retire_counter (CNT_W, inc, rst).

Test Plan:
- rst=1 for 2 cycles, then release -> all strobes 0 during reset; state=FETCH, mem_read=1, retired_count=0 after release.
- RTYPE (0x00), mem_ready=1 -> states 0,1,6,7,0. reg_write=1 with reg_dst=1 only in R_WB. retired_count=1.
- LB (0x20), mem_ready low for 2 cycles in MEM_READ -> states 0,1,2,3,3,3,4,0 (7 cycles). iord=1 throughout MEM_READ. reg_write only in MEM_WB.
- BGEZ (0x01) then BEQ (0x04) -> branch_ge=1 then 0 in BRANCH. pc_write_cond=1 for exactly one cycle each. retired_count=2.
- Opcode 0x3F, then J (0x02) -> illegal_op=1 after DECODE; count unchanged. J runs 0,1,9,0 with pc_source=10; illegal_op stays 1.
- Preload retired_count to 0xFFFF, retire ADDI (0x08) -> count=0x0000. Separately, rst asserted during MEM_WRITE -> mem_write=0 at the next edge; state=FETCH.
